// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if - bundle of core, DMA and DATA_MEM signals around dmem_arbiter.
//   slave  : arbiter view (core/DMA requests and mem_rd in; memory port, grants, core reset out)
//   master : environment view (core, DMA requester and DATA_MEM model)
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wd;
  logic              core_we;
  logic              core_re;
  logic [DATA_W-1:0] core_rd;
  logic              core_rst_n;
  logic              core_hold;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic              dm_we;
  logic [DATA_W-1:0] mem_rd;
  logic              clear_done;

  modport slave (
    input  core_addr, core_wd, core_we, core_re,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rd,
    output core_rd, core_rst_n, core_hold,
    output dma_gnt, dma_rdata,
    output mem_addr, mem_wd, dm_we,
    output clear_done
  );

  modport master (
    output core_addr, core_wd, core_we, core_re,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rd,
    input  core_rd, core_rst_n, core_hold,
    input  dma_gnt, dma_rdata,
    input  mem_addr, mem_wd, dm_we,
    input  clear_done
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter - shares the single DATA_MEM port between the RISC-V core and a
// DMA/debug requester. After reset it zero-fills memory while the core is held
// in reset, then runs with core priority and a starvation guard for DMA.
//   clk  : system clock
//   rset : asynchronous active-low reset
//   bus  : core, DMA and memory signals (dmem_arbiter_if.slave)
//
// state   | meaning
// S_CLEAR | writing zero to address r_clr_cnt, core held in reset
// S_RUN   | normal arbitration between core and DMA
module dmem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 256,
  parameter int STARVE_LIM = 8,
  parameter bit CLEAR_EN   = 1'b1
) (
  input  logic           clk,
  input  logic           rset,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  localparam state_t            ST_RESET   = CLEAR_EN ? S_CLEAR : S_RUN;
  localparam logic [ADDR_W-1:0] CLR_LAST   = ADDR_W'(DEPTH - 1);
  localparam logic [7:0]        STARVE_TOP = 8'(STARVE_LIM - 1);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt, w_clr_cnt_nxt;
  logic [7:0]        r_starve_cnt, w_starve_nxt;
  logic              r_core_hold, w_hold_nxt;
  logic              r_core_rst_n;
  logic              r_clear_done;
  logic              w_run_nxt;

  logic              w_dma_own;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wd;
  logic              w_dm_we;
  logic              w_dma_gnt;

  always_ff @(posedge clk or negedge rset) begin
    if (!rset) begin
      r_state      <= ST_RESET;
      r_clr_cnt    <= '0;
      r_starve_cnt <= '0;
      r_core_hold  <= 1'b0;
      r_core_rst_n <= 1'b0;
      r_clear_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_clr_cnt    <= w_clr_cnt_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_core_hold  <= w_hold_nxt;
      r_core_rst_n <= w_run_nxt;
      r_clear_done <= w_run_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_starve_nxt  = r_starve_cnt;
    w_hold_nxt    = 1'b0;
    w_dma_own     = 1'b0;
    w_mem_addr    = '0;
    w_mem_wd      = '0;
    w_dm_we       = 1'b0;
    w_dma_gnt     = 1'b0;

    case (r_state)
      S_CLEAR: begin
        w_mem_addr    = r_clr_cnt;
        w_dm_we       = 1'b1;
        w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        if (r_clr_cnt == CLR_LAST) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // A hold cycle hands the port to DMA regardless of what the core presents.
        w_dma_own = r_core_hold | (~(bus.core_we | bus.core_re) & bus.dma_req);
        if (w_dma_own) begin
          w_mem_addr = bus.dma_addr;
          w_mem_wd   = bus.dma_wdata;
          // Gate with dma_req so a stale dma_we cannot write when nothing is requested.
          w_dm_we    = bus.dma_we & bus.dma_req;
          w_dma_gnt  = bus.dma_req;
        end else begin
          w_mem_addr = bus.core_addr;
          w_mem_wd   = bus.core_wd;
          w_dm_we    = bus.core_we;
        end
        if (bus.dma_req && !w_dma_gnt) begin
          w_starve_nxt = r_starve_cnt + 8'd1;
          w_hold_nxt   = (r_starve_cnt == STARVE_TOP);
        end else begin
          w_starve_nxt = '0;
        end
      end
      default: w_state_nxt = ST_RESET;
    endcase

    // Memory-side outputs must be quiet for the whole reset pulse, not just after a clock.
    if (!rset) begin
      w_mem_addr = '0;
      w_mem_wd   = '0;
      w_dm_we    = 1'b0;
      w_dma_gnt  = 1'b0;
    end
  end

  assign w_run_nxt = (w_state_nxt == S_RUN);

  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_wd     = w_mem_wd;
  assign bus.dm_we      = w_dm_we;
  assign bus.dma_gnt    = w_dma_gnt;
  assign bus.dma_rdata  = bus.mem_rd;
  assign bus.core_rd    = bus.mem_rd;
  assign bus.core_hold  = r_core_hold;
  assign bus.core_rst_n = r_core_rst_n;
  assign bus.clear_done = r_clear_done;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Data-memory controller between the pipelined RISC-V core (`RISCV_TOP`) and the single-port `DATA_MEM` (8-bit word address, 32-bit data, combinational read, write on `clk` rising edge). After reset it zero-fills the memory while holding the core in reset. It then releases the core and shares the memory port between the core and a DMA/debug requester. The core has priority; a starvation guard briefly holds the core so the DMA side always makes progress.

## Interface
- `ADDR_W`, 8: memory word-address width.
- `DATA_W`, 32: data width.
- `DEPTH`, 256: words cleared after reset; must equal 2^ADDR_W.
- `STARVE_LIM`, 8: consecutive denied DMA cycles before a forced grant; range 1..255.
- `CLEAR_EN`, 1: 1 = zero-fill after reset; 0 = go straight to RUN.

Ports:
- `clk` in 1: single clock.
- `rset` in 1: reset, asynchronous, active-low.
- `core_addr` in ADDR_W: core data address.
- `core_wd` in DATA_W: core write data.
- `core_we` in 1: core store.
- `core_re` in 1: core load.
- `core_rd` out DATA_W: read data to core, equal to `mem_rd`.
- `core_rst_n` out 1: active-low reset to the core, registered.
- `core_hold` out 1: pipeline freeze request, registered.
- `dma_req` in 1: DMA access request.
- `dma_we` in 1: DMA write (1) or read (0).
- `dma_addr` in ADDR_W: DMA address.
- `dma_wdata` in DATA_W: DMA write data.
- `dma_gnt` out 1: access performed this cycle.
- `dma_rdata` out DATA_W: read data, valid while `dma_gnt`=1.
- `mem_addr` out ADDR_W: to `DATA_MEM`.
- `mem_wd` out DATA_W: to `DATA_MEM`.
- `dm_we` out 1: to `DATA_MEM`.
- `mem_rd` in DATA_W: from `DATA_MEM`.
- `clear_done` out 1: high once the CLEAR state has finished.

## Operation
- States are CLEAR and RUN. Reset enters CLEAR if `CLEAR_EN`=1, otherwise RUN.
- Reset values:
  - state CLEAR (RUN if `CLEAR_EN`=0); `clr_cnt`=0; `starve_cnt`=0.
  - `core_hold`=0; `core_rst_n`=0; `clear_done`=0.
  - `dm_we`=0, `mem_addr`=0, `mem_wd`=0, `dma_gnt`=0. These outputs are forced while `rset`=0.
- CLEAR:
  - `mem_addr`=`clr_cnt`, `mem_wd`=0, `dm_we`=1.
  - `clr_cnt` increments each cycle. At `clr_cnt`=DEPTH-1 the next state is RUN.
  - Core and DMA inputs are ignored and `dma_gnt`=0.
- Entering RUN: `core_rst_n` and `clear_done` go to 1 on the same edge that enters RUN. With `CLEAR_EN`=0 this is the first edge after reset release.
- RUN port selection (combinational):
  - If `core_hold`=1: DMA owns the port. The core inputs are ignored that cycle and the core re-presents its access after the hold.
  - Else if `core_we`|`core_re`: the core owns the port and DMA is denied.
  - Else if `dma_req`: DMA owns the port.
  - Else: core owns the port, `dm_we`=0.
- When DMA owns the port:
  - `mem_addr`=`dma_addr`, `mem_wd`=`dma_wdata`, `dm_we`=`dma_we`.
  - `dma_gnt`=`dma_req`; `dma_rdata`=`mem_rd`.
- When the core owns the port: `mem_addr`=`core_addr`, `mem_wd`=`core_wd`, `dm_we`=`core_we`.
- DMA handshake:
  - The requester holds `dma_req`/`dma_we`/`dma_addr`/`dma_wdata` stable until it sees `dma_gnt`=1.
  - A write commits at the end of the granted cycle.
  - A new request may be presented on the next cycle.
- Starvation counter `starve_cnt` (8-bit):
  - Increments in each RUN cycle with `dma_req`=1 and `dma_gnt`=0.
  - Clears on a grant or when `dma_req`=0.
  - If it equals STARVE_LIM-1 in a denied cycle, `core_hold` is set on the next edge.
  - `core_hold` lasts exactly one cycle. It clears on the following edge, and `starve_cnt` returns to 0.
- Simultaneous core access and `dma_req` outside a hold cycle: the core wins. Every such denied cycle counts toward starvation.
- `rset` low mid-CLEAR or mid-RUN: immediate return to reset values; CLEAR restarts from address 0.

## Timing
- CLEAR lasts DEPTH cycles. `core_rst_n` rises DEPTH edges after the first `clk` edge with `rset`=1.
- DMA read latency: 0 cycles; data is valid in the grant cycle. DMA write is visible to reads on the next cycle.
- Worst-case DMA wait under continuous core traffic is STARVE_LIM+1 cycles from request to grant.
- `core_rd` is a purely combinational pass-through; its value is meaningful only in core-owned cycles.

## Test plan
- Reset release with `CLEAR_EN`=1 and preloaded nonzero memory:
  - `dm_we`=1 for addresses 0..255 in order.
  - `core_rst_n`, `clear_done` rise after 256 cycles.
  - Every word reads 0 afterwards.
- RUN with `core_re`=0, `core_we`=0: DMA write 0xDEADBEEF to 0x10, `dma_gnt`=1 in the same cycle. The next-cycle DMA read of 0x10 returns 0xDEADBEEF.
- Core store of 0x12345678 to 0x20 together with a DMA read of 0x30: core write commits and `dma_gnt`=0. The DMA is granted in the first cycle without a core access.
- Continuous core loads with `dma_req` held for 0x05:
  - `core_hold`=1 exactly on the 9th cycle of the request, with `dma_gnt`=1 in that cycle.
  - Hold returns to 0 the cycle after; `starve_cnt` returns to 0.
- `rset` pulsed low at `clr_cnt`=100: outputs return to reset values at once, CLEAR restarts at address 0, and 256 full cycles run before `core_rst_n`=1.
- `CLEAR_EN`=0: `core_rst_n`=1 after the first edge following reset release, with no memory writes.
